// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: splits scalar/vector load-store instructions into per-lane word accesses
module vector_mem_sequencer #(
  parameter int LANES = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_write,
  input  logic                      is_vector,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANES*DATA_W-1:0]   store_data,
  output logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*DATA_W-1:0]   load_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic we_q, we_d, vec_q, vec_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LANES*DATA_W-1:0] sd_q, sd_d, ld_q, ld_d;
  logic last, acc;
  assign last = vec_q ? (lane_q == LW'(LANES - 1)) : (lane_q == '0);
  assign acc = !rst && state_q == ACCESS;
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    we_d = we_q;
    vec_d = vec_q;
    base_d = base_q;
    sd_d = sd_q;
    ld_d = ld_q;
    if (state_q == IDLE && start) begin
      state_d = ACCESS;
      lane_d = '0;
      ld_d = '0;
      we_d = is_write;
      vec_d = is_vector;
      base_d = base_addr;
      sd_d = store_data;
    end else if (state_q == ACCESS && mem_ack) begin
      state_d = last ? DONE : ACCESS;
      lane_d = last ? lane_q : lane_q + 1'b1;
      if (!we_q) ld_d[lane_q*DATA_W +: DATA_W] = mem_rdata;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q <= '0;
      we_q <= 1'b0;
      vec_q <= 1'b0;
      base_q <= '0;
      sd_q <= '0;
      ld_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      we_q <= we_d;
      vec_q <= vec_d;
      base_q <= base_d;
      sd_q <= sd_d;
      ld_q <= ld_d;
    end
  end
  assign stall = !rst && ((state_q == IDLE && start) || state_q == ACCESS);
  assign busy = !rst && state_q != IDLE;
  assign done = !rst && state_q == DONE;
  assign load_data = rst ? '0 : ld_q;
  assign mem_req = acc;
  assign mem_we = acc && we_q;
  assign mem_addr = acc ? base_q + ADDR_W'(lane_q) : '0;
  assign mem_wdata = acc ? sd_q[lane_q*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: randomized bench with a memory model and per-instruction access reference
module tb_vector_mem_sequencer;
  logic clk, rst, start, is_write, is_vector;
  logic [15:0] base_addr;
  logic [31:0] store_data;
  logic stall, busy, done, mem_req, mem_we, mem_ack;
  logic [31:0] load_data;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [60:0] outs;
  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] d;} acc_t;
  acc_t acc_q[$];
  acc_t p;
  logic [7:0] mem [0:65535];
  logic [31:0] last_ld;
  int n_vec, n_err, cnt, cur_w, wait_sum, wmode;
  bit pending;

  vector_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_write(is_write), .is_vector(is_vector),
    .base_addr(base_addr), .store_data(store_data), .stall(stall), .busy(busy), .done(done),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  assign outs = {stall, busy, done, load_data, mem_req, mem_we, mem_addr, mem_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (mem_req) begin
      if (!pending) begin
        cur_w = wmode < 0 ? int'($urandom_range(0, 3)) : wmode;
        wait_sum += cur_w;
        cnt = 0;
        pending = 1;
        p = '{we: mem_we, addr: mem_addr, d: mem_wdata};
      end else begin
        check("hold_addr", mem_addr, p.addr);
        check("hold_we", mem_we, p.we);
        check("hold_wdata", mem_wdata, p.d);
      end
      mem_ack = (cnt == cur_w);
      mem_rdata = mem[mem_addr];
      if (mem_ack) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        acc_q.push_back(p);
        pending = 0;
      end else cnt++;
    end else begin
      pending = 0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
  end

  task automatic run(input logic w, input logic v, input logic [15:0] base, input logic [31:0] sd,
                     input int wm, input logic hold);
    int n, k_done, st_cnt;
    logic [31:0] exp_ld;
    logic [15:0] a;
    n = v ? 4 : 1;
    exp_ld = '0;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (!w) exp_ld[i*8 +: 8] = mem[a];
    end
    @(negedge clk);
    check("ld_hold", load_data, last_ld);
    check("busy_idle", busy, 0);
    acc_q.delete();
    wait_sum = 0;
    wmode = wm;
    start = 1;
    is_write = w;
    is_vector = v;
    base_addr = base;
    store_data = sd;
    #1 check("stall_accept", stall, 1);
    k_done = 0;
    st_cnt = 1;
    for (int k = 1; k <= 200 && k_done == 0; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) check("ld_clear", load_data, 0);
      if (done) k_done = k;
      else begin
        st_cnt += int'(stall);
        check("req_access", mem_req, 1);
        is_write = 1'($urandom);
        is_vector = 1'($urandom);
        base_addr = 16'($urandom);
        store_data = $urandom;
      end
    end
    check("done_cycle", k_done, n + wait_sum + 1);
    check("stall_cycles", st_cnt, n + wait_sum + 1);
    check("stall_done", stall, 0);
    check("req_done", mem_req, 0);
    check("busy_done", busy, 1);
    check("load_data", load_data, exp_ld);
    check("n_access", acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      a = base + 16'(i);
      check("acc_addr", acc_q[i].addr, a);
      check("acc_we", acc_q[i].we, w);
      if (w) check("acc_data", acc_q[i].d, sd[i*8 +: 8]);
    end
    last_ld = exp_ld;
    start = hold;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wmode = 0;
    wait_sum = 0;
    pending = 0;
    mem_ack = 0;
    mem_rdata = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA5;
    for (int i = 0; i < 4; i++) mem[16'h0020 + i] = 8'(i + 1);
    rst = 1;
    start = 1;
    is_write = 1;
    is_vector = 1;
    base_addr = 16'h1234;
    store_data = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      #1 check("reset_outs", outs, 0);
    end
    rst = 0;
    start = 0;
    last_ld = 0;
    @(negedge clk);
    #1 check("post_reset_outs", outs, 0);
    run(0, 0, 16'h0010, 32'h0, 0, 0);
    run(1, 1, 16'h0100, 32'h44332211, 0, 0);
    for (int i = 0; i < 4; i++) check("store_mem", mem[16'h0100 + i], 8'(8'h11 * (i + 1)));
    run(0, 1, 16'h0020, 32'hFFFFFFFF, 2, 0);
    run(0, 1, 16'hFFFE, 32'h0, 0, 0);
    @(negedge clk);
    acc_q.delete();
    wmode = 0;
    start = 1;
    is_write = 1;
    is_vector = 1;
    base_addr = 16'h0200;
    store_data = 32'h8877_6655;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1;
    start = 0;
    #1 check("rst_mid_outs", outs, 0);
    @(negedge clk);
    #1 check("rst_idle_outs", outs, 0);
    check("rst_accesses", acc_q.size(), 2);
    rst = 0;
    last_ld = 0;
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_no_done", done, 0);
    end
    run(0, 0, 16'h0010, 32'h0, 0, 0);
    run(0, 1, 16'h0020, 32'h0, 0, 1);
    run(0, 0, 16'h0010, 32'h0, 0, 0);
    for (int t = 0; t < 25; t++)
      run(1'($urandom), 1'($urandom), 16'($urandom), $urandom, -1, 1'($urandom));
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
